// File: rtl/ov_cam_pkg.sv
// ov_cam_pkg: shared entry encodings, OV7670 register map, entry helpers and sequencer state type
// (OV_REGSEQ_DELAY_EN adds the DELAY state).
package ov_cam_pkg;

    localparam logic [15:0] OV_CMD_END        = 16'hFFFF;
    localparam logic [7:0]  OV_CMD_DELAY_ADDR = 8'hF0;

    localparam logic [7:0] OV_REG_VREF          = 8'h03;
    localparam logic [7:0] OV_REG_COM3          = 8'h0C;
    localparam logic [7:0] OV_REG_CLKRC         = 8'h11;
    localparam logic [7:0] OV_REG_COM7          = 8'h12;
    localparam logic [7:0] OV_REG_COM10         = 8'h15;
    localparam logic [7:0] OV_REG_HSTART        = 8'h17;
    localparam logic [7:0] OV_REG_HSTOP         = 8'h18;
    localparam logic [7:0] OV_REG_VSTART        = 8'h19;
    localparam logic [7:0] OV_REG_VSTOP         = 8'h1A;
    localparam logic [7:0] OV_REG_HREF          = 8'h32;
    localparam logic [7:0] OV_REG_TSLB          = 8'h3A;
    localparam logic [7:0] OV_REG_COM13         = 8'h3D;
    localparam logic [7:0] OV_REG_COM14         = 8'h3E;
    localparam logic [7:0] OV_REG_COM15         = 8'h40;
    localparam logic [7:0] OV_REG_SCALING_XSC   = 8'h70;
    localparam logic [7:0] OV_REG_SCALING_YSC   = 8'h71;
    localparam logic [7:0] OV_REG_SCALING_DCW   = 8'h72;
    localparam logic [7:0] OV_REG_SCALING_PCLK  = 8'h73;
    localparam logic [7:0] OV_REG_SCALING_PDLY  = 8'hA2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_ISSUE,
`ifdef OV_REGSEQ_DELAY_EN
        ST_DELAY,
`endif
        ST_DONE,
        ST_ERROR
    } ov_state_e;

    function automatic logic [15:0] ov_wr(input logic [7:0] a, input logic [7:0] d);
        return {a, d};
    endfunction

    function automatic logic [15:0] ov_dly(input logic [7:0] n);
        return {OV_CMD_DELAY_ADDR, n};
    endfunction

endpackage

// File: rtl/ov7670_reg_rom.sv
// ov7670_reg_rom: per-profile register tables with a registered (1-cycle) read port.
module ov7670_reg_rom
    import ov_cam_pkg::*;
#(
    parameter int IDX_W  = 6,
    parameter int PROF_W = 1
) (
    input  logic              clk,
    input  logic [PROF_W-1:0] profile,
    input  logic [IDX_W-1:0]  index,
    output logic [15:0]       entry
);

    logic [7:0]  a;
    logic [15:0] vga, qvga;

    // Table lookup; anything past a table's END also reads as END
    always_comb begin
        a = 8'(index);
        case (a)
            8'd0:    vga = ov_wr(OV_REG_COM7, 8'h80);
            8'd1:    vga = ov_dly(8'd10);
            8'd2:    vga = ov_wr(OV_REG_CLKRC, 8'h01);
            8'd3:    vga = ov_wr(OV_REG_COM7, 8'h04);
            8'd4:    vga = ov_wr(OV_REG_COM15, 8'hD0);
            8'd5:    vga = ov_wr(OV_REG_TSLB, 8'h04);
            default: vga = OV_CMD_END;
        endcase
        case (a)
            8'd0:    qvga = ov_wr(OV_REG_COM7, 8'h80);
            8'd1:    qvga = ov_wr(OV_REG_CLKRC, 8'h01);
            8'd2:    qvga = ov_wr(OV_REG_COM7, 8'h00);
            8'd3:    qvga = ov_wr(OV_REG_COM3, 8'h04);
            8'd4:    qvga = ov_wr(OV_REG_COM14, 8'h19);
            8'd5:    qvga = ov_wr(OV_REG_SCALING_XSC, 8'h3A);
            8'd6:    qvga = ov_wr(OV_REG_SCALING_YSC, 8'h35);
            8'd7:    qvga = ov_wr(OV_REG_SCALING_DCW, 8'h11);
            8'd8:    qvga = ov_wr(OV_REG_SCALING_PCLK, 8'hF1);
            8'd9:    qvga = ov_wr(OV_REG_SCALING_PDLY, 8'h02);
            8'd10:   qvga = ov_wr(OV_REG_COM10, 8'h00);
            8'd11:   qvga = ov_wr(OV_REG_TSLB, 8'h04);
            8'd12:   qvga = ov_wr(OV_REG_COM13, 8'h88);
            8'd13:   qvga = ov_wr(OV_REG_COM15, 8'hC0);
            8'd14:   qvga = ov_wr(OV_REG_HSTART, 8'h16);
            8'd15:   qvga = ov_wr(OV_REG_HSTOP, 8'h04);
            8'd16:   qvga = ov_wr(OV_REG_HREF, 8'h24);
            8'd17:   qvga = ov_wr(OV_REG_VSTART, 8'h02);
            8'd18:   qvga = ov_wr(OV_REG_VSTOP, 8'h7A);
            8'd19:   qvga = ov_wr(OV_REG_VREF, 8'h0A);
            default: qvga = OV_CMD_END;
        endcase
    end

    // Registered read: entry reflects the index presented one edge earlier
    always_ff @(posedge clk) entry <= (profile == PROF_W'(0)) ? vga : qvga;

endmodule

// File: rtl/ov7670_reg_sequencer.sv
// ov7670_reg_sequencer: walks a selected register table and issues writes to the SCCB master.
// Define OV_REGSEQ_DELAY_EN to honour in-table DELAY opcodes; otherwise they are skipped.
module ov7670_reg_sequencer
    import ov_cam_pkg::*;
#(
    parameter int DEPTH          = 64,
    parameter int IDX_W          = $clog2(DEPTH),
    parameter int NUM_PROFILES   = 2,
    parameter int PROF_W         = 1,
    parameter int DELAY_UNIT_CYC = 25000,
    parameter int ACK_TIMEOUT    = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [PROF_W-1:0] profile,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [7:0]        cmd_addr,
    output logic [7:0]        cmd_data,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [IDX_W-1:0]  index
);

    localparam int TO_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(ACK_TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DEPTH - 1);

    ov_state_e         state_q;
    logic [PROF_W-1:0] profile_q;
    logic [IDX_W-1:0]  index_q, index_d;
    logic [TO_W-1:0]   wait_q;
    logic [7:0]        addr_q, data_q;
    logic              valid_q, busy_q, done_q, error_q;
    logic [15:0]       entry;
    logic              bad_prof, is_end, is_dly, last, fin;

    ov7670_reg_rom #(
        .IDX_W (IDX_W),
        .PROF_W(PROF_W)
    ) u_rom (
        .clk    (clk),
        .profile(profile_q),
        .index  (index_q),
        .entry  (entry)
    );

    assign bad_prof = int'(profile) >= NUM_PROFILES;
    assign is_end   = entry == OV_CMD_END;
    assign is_dly   = entry[15:8] == OV_CMD_DELAY_ADDR;
    assign last     = index_q == IDX_LAST;
    assign index_d  = last ? index_q : index_q + IDX_W'(1);

`ifdef OV_REGSEQ_DELAY_EN
    localparam int DLY_W = $clog2(255 * DELAY_UNIT_CYC + 1);
    localparam logic [DLY_W-1:0] DLY_UNIT = DLY_W'(DELAY_UNIT_CYC);

    logic [DLY_W-1:0] dly_q;
    logic             dly_go;

    assign dly_go = entry[7:0] != 8'd0;

    // An entry completes on accept, on a zero-length delay, or when the delay count expires
    always_comb fin = (state_q == ST_ISSUE && cmd_ready) || (state_q == ST_DECODE && is_dly && !dly_go)
                      || (state_q == ST_DELAY && dly_q == '0);

    // Delay countdown: loaded with n*unit-1 so the DELAY state lasts exactly n*unit cycles
    always_ff @(posedge clk) begin
        if (rst) dly_q <= '0;
        else if (state_q == ST_DECODE && is_dly && dly_go) dly_q <= DLY_W'(entry[7:0]) * DLY_UNIT - DLY_W'(1);
        else if (dly_q != '0) dly_q <= dly_q - DLY_W'(1);
    end
`else
    // An entry completes on accept, or immediately for a (skipped) delay opcode
    always_comb fin = (state_q == ST_ISSUE && cmd_ready) || (state_q == ST_DECODE && is_dly);
`endif

    // Sequencer FSM with registered handshake and status outputs; entry completion overrides last
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            profile_q <= '0;
            index_q   <= '0;
            wait_q    <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE, ST_ERROR: if (start) begin
                    state_q   <= bad_prof ? ST_ERROR : ST_FETCH;
                    profile_q <= profile;
                    index_q   <= '0;
                    busy_q    <= !bad_prof;
                    done_q    <= 1'b0;
                    error_q   <= bad_prof;
                end
                ST_FETCH: state_q <= ST_DECODE;
                ST_DECODE: begin
                    if (is_end) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (!is_dly) begin
                        state_q <= ST_ISSUE;
                        addr_q  <= entry[15:8];
                        data_q  <= entry[7:0];
                        valid_q <= 1'b1;
                        wait_q  <= '0;
                    end
`ifdef OV_REGSEQ_DELAY_EN
                    else if (dly_go) state_q <= ST_DELAY;
`endif
                end
                ST_ISSUE: begin
                    if (cmd_ready) valid_q <= 1'b0;
                    else if (wait_q == TO_LAST) begin
                        state_q <= ST_ERROR;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        error_q <= 1'b1;
                    end else wait_q <= wait_q + TO_W'(1);
                end
                default: ;
            endcase
            if (fin) begin
                state_q <= last ? ST_DONE : ST_FETCH;
                index_q <= index_d;
                busy_q  <= !last;
                done_q  <= last;
            end
        end
    end

    assign cmd_valid = valid_q;
    assign cmd_addr  = addr_q;
    assign cmd_data  = data_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign index     = index_q;

endmodule

// File: tb/tb_ov7670_reg_sequencer.sv
// tb_ov7670_reg_sequencer: vector table, directed corner cases and randomized runs against a cost model.
module tb_ov7670_reg_sequencer;

    localparam int DEPTH = 8;
    localparam int NPROF = 2;
    localparam int PW    = 2;
    localparam int UNIT  = 4;
    localparam int TO    = 16;
`ifdef OV_REGSEQ_DELAY_EN
    localparam bit DLY_EN = 1'b1;
`else
    localparam bit DLY_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, start, cmd_ready, cmd_valid, busy, done, error;
    logic [PW-1:0] profile;
    logic [7:0]    cmd_addr, cmd_data;
    logic [2:0]    index;

    int ncmp = 0;
    int nfail = 0;
    logic [15:0] tbl [2][8];
    logic [15:0] exp_wr[$], got_wr[$];
    int exp_acc[$], got_acc[$];
    int exp_done, exp_end;

    typedef struct {int prof; int stall; int nwr; int done; int err; int idx;} vec_t;
    vec_t vecs[8];

    always #5 clk = ~clk;

    ov7670_reg_sequencer #(
        .DEPTH(DEPTH), .NUM_PROFILES(NPROF), .PROF_W(PW), .DELAY_UNIT_CYC(UNIT), .ACK_TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .profile(profile), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .busy(busy),
        .done(done), .error(error), .index(index)
    );

    task automatic chk(input string nm, input int act, input int expv);
        ncmp++;
        if (act !== expv) begin
            nfail++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", nm, act, act, expv, expv);
        end
    endtask

    // Cost model: write = 3 edges (FETCH, DECODE, ISSUE), skipped delay = 2, enabled delay = 2 + n*UNIT,
    // END = done 2 edges after the previous entry completes; running off the table ends on the last completion.
    function automatic void model(input int prof);
        int pos = 0;
        logic [15:0] e;
        exp_wr.delete();
        exp_acc.delete();
        exp_done = -1;
        exp_end = DEPTH - 1;
        for (int i = 0; i < DEPTH; i++) begin
            e = tbl[prof][i];
            if (e == 16'hFFFF) begin
                exp_done = pos + 2;
                exp_end = i;
                return;
            end
            if (e[15:8] == 8'hF0) pos += 2 + (DLY_EN ? int'(e[7:0]) * UNIT : 0);
            else begin
                pos += 3;
                exp_wr.push_back(e);
                exp_acc.push_back(pos);
            end
        end
        exp_done = pos;
    endfunction

    // Start a run and follow it to done/error; stall = ready-low cycles per write (<0: random ready),
    // stall_at selects the only stalled write (<0: all), noise pulses start/profile while busy.
    task automatic run(input int prof, input int stall, input int stall_at, input bit noise,
                       output int done_e, output int err_e, output int stable, output int err0, output int b0);
        int e = 0;
        int w = 0;
        int nw = 0;
        int st;
        logic [15:0] held = '0;
        logic [15:0] cur;
        bit acc, vpre;
        got_wr.delete();
        got_acc.delete();
        done_e = -1;
        err_e = -1;
        stable = 1;
        profile = PW'(prof);
        cmd_ready = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        err0 = int'(error);
        b0 = int'(busy);
        while (e <= 2000) begin
            if (done) begin done_e = e; break; end
            if (error) begin err_e = e; break; end
            cur = {cmd_addr, cmd_data};
            if (cmd_valid && w == 0) held = cur;
            if (cmd_valid && cur != held) stable = 0;
            st = (stall_at < 0 || nw == stall_at) ? stall : 0;
            if (stall < 0) cmd_ready = $urandom_range(0, 2) != 0;
            else cmd_ready = !cmd_valid || w >= st;
            start = 1'b0;
            if (noise && busy) begin
                start = $urandom_range(0, 5) == 0;
                profile = PW'($urandom_range(0, 3));
            end
            vpre = cmd_valid;
            acc = cmd_valid && cmd_ready;
            @(posedge clk); #1;
            e++;
            if (acc) begin
                got_wr.push_back(cur);
                got_acc.push_back(e);
                nw++;
            end
            w = (vpre && !acc) ? w + 1 : 0;
        end
        start = 1'b0;
        cmd_ready = 1'b0;
        chk("run_finished", int'(done_e >= 0 || err_e >= 0), 1);
    endtask

    initial begin
        int de, ee, st, e0, b0, n, p;
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int de, ee, st, e0, b0, n, p;
        tbl[0] = '{16'h1280, 16'hF00A, 16'h1101, 16'h1204, 16'h40D0, 16'h3A04, 16'hFFFF, 16'hFFFF};
        tbl[1] = '{16'h1280, 16'h1101, 16'h1200, 16'h0C04, 16'h3E19, 16'h703A, 16'h7135, 16'h7211};
        vecs[0] = '{0, 0, 5, 1, 0, 6};
        vecs[1] = '{1, 0, 8, 1, 0, 7};
        vecs[2] = '{2, 0, 0, 0, 1, 0};
        vecs[3] = '{3, 0, 0, 0, 1, 0};
        vecs[4] = '{1, 3, 8, 1, 0, 7};
        vecs[5] = '{0, 16, 0, 0, 1, 0};
        vecs[6] = '{0, 15, 5, 1, 0, 6};
        vecs[7] = '{0, 0, 5, 1, 0, 6};

        rst = 1'b1; start = 1'b0; cmd_ready = 1'b0; profile = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_outputs", int'({cmd_valid, cmd_addr, cmd_data, busy, done, error, index}), 0);

        // Exact timing with ready held high
        for (int pr = 0; pr < NPROF; pr++) begin
            model(pr);
            run(pr, 0, -1, 1'b0, de, ee, st, e0, b0);
            chk($sformatf("p%0d_busy_after_start", pr), b0, 1);
            chk($sformatf("p%0d_nwr", pr), got_wr.size(), exp_wr.size());
            for (int k = 0; k < got_wr.size() && k < exp_wr.size(); k++) begin
                chk($sformatf("p%0d_wr%0d", pr, k), int'(got_wr[k]), int'(exp_wr[k]));
                chk($sformatf("p%0d_acc_edge%0d", pr, k), got_acc[k], exp_acc[k]);
            end
            chk($sformatf("p%0d_done_edge", pr), de, exp_done);
            chk($sformatf("p%0d_index", pr), int'(index), exp_end);
            chk($sformatf("p%0d_busy_end", pr), int'(busy), 0);
        end

        // Third write stalled 10 cycles: same stream, stable command, later accepts shifted by 10
        model(0);
        run(0, 10, 2, 1'b0, de, ee, st, e0, b0);
        chk("stall_stable", st, 1);
        chk("stall_nwr", got_wr.size(), exp_wr.size());
        for (int k = 0; k < got_wr.size() && k < exp_wr.size(); k++) begin
            chk($sformatf("stall_wr%0d", k), int'(got_wr[k]), int'(exp_wr[k]));
            chk($sformatf("stall_acc%0d", k), got_acc[k], exp_acc[k] + (k >= 2 ? 10 : 0));
        end
        chk("stall_done", int'(done), 1);

        // Ready never asserted: error exactly TO cycles after cmd_valid rises, then a rerun clears it
        run(0, 100000, -1, 1'b0, de, ee, st, e0, b0);
        chk("timeout_edge", ee, 2 + TO);
        chk("timeout_valid", int'(cmd_valid), 0);
        chk("timeout_busy", int'(busy), 0);
        chk("timeout_nwr", got_wr.size(), 0);
        model(0);
        run(0, 0, -1, 1'b0, de, ee, st, e0, b0);
        chk("rerun_error_cleared", e0, 0);
        chk("rerun_done_edge", de, exp_done);
        chk("rerun_nwr", got_wr.size(), exp_wr.size());

        // Bad profile: error on the start edge, nothing issued
        run(2, 0, -1, 1'b0, de, ee, st, e0, b0);
        chk("badprof_err_edge", ee, 0);
        chk("badprof_busy", b0, 0);
        chk("badprof_nwr", got_wr.size(), 0);

        // Vector table
        for (int i = 0; i < 8; i++) begin
            run(vecs[i].prof, vecs[i].stall, -1, 1'b0, de, ee, st, e0, b0);
            chk($sformatf("vec%0d_nwr", i), got_wr.size(), vecs[i].nwr);
            chk($sformatf("vec%0d_done", i), int'(done), vecs[i].done);
            chk($sformatf("vec%0d_error", i), int'(error), vecs[i].err);
            chk($sformatf("vec%0d_index", i), int'(index), vecs[i].idx);
            chk($sformatf("vec%0d_valid_busy", i), int'({cmd_valid, busy}), 0);
            if (vecs[i].prof < NPROF) begin
                model(vecs[i].prof);
                for (int k = 0; k < got_wr.size() && k < exp_wr.size(); k++)
                    chk($sformatf("vec%0d_wr%0d", i, k), int'(got_wr[k]), int'(exp_wr[k]));
            end
        end

        // Reset in the middle of a pending handshake
        profile = '0; cmd_ready = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (!cmd_valid && n < 10) begin @(posedge clk); #1; n++; end
        chk("rst_valid_seen", int'(cmd_valid), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_mid_issue", int'({cmd_valid, cmd_addr, cmd_data, busy, done, error, index}), 0);

        // Randomized ready, random profiles, ignored starts while busy
        for (int it = 0; it < 24; it++) begin
            p = $urandom_range(0, 3);
            run(p, -1, -1, 1'b1, de, ee, st, e0, b0);
            chk($sformatf("rnd%0d_stable", it), st, 1);
            if (p < NPROF) begin
                model(p);
                chk($sformatf("rnd%0d_nwr", it), got_wr.size(), exp_wr.size());
                for (int k = 0; k < got_wr.size() && k < exp_wr.size(); k++)
                    chk($sformatf("rnd%0d_wr%0d", it, k), int'(got_wr[k]), int'(exp_wr[k]));
                chk($sformatf("rnd%0d_done_err", it), int'({done, error}), 2);
                chk($sformatf("rnd%0d_index", it), int'(index), exp_end);
            end else begin
                chk($sformatf("rnd%0d_bad_err", it), int'({done, error}), 1);
                chk($sformatf("rnd%0d_bad_nwr", it), got_wr.size(), 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
